// File: rtl/branch_pkg.sv
// Shared definitions for the RV32I branch resolution unit: op encodings and
// decode helpers.
package branch_pkg;

    localparam int unsigned OP_W        = 4;
    localparam int unsigned LINK_OFFSET = 4;

    localparam logic [OP_W-1:0] OP_BEQ  = 4'b0000;
    localparam logic [OP_W-1:0] OP_BNE  = 4'b0001;
    localparam logic [OP_W-1:0] OP_BLT  = 4'b0100;
    localparam logic [OP_W-1:0] OP_BGE  = 4'b0101;
    localparam logic [OP_W-1:0] OP_BLTU = 4'b0110;
    localparam logic [OP_W-1:0] OP_BGEU = 4'b0111;
    localparam logic [OP_W-1:0] OP_JAL  = 4'b1000;
    localparam logic [OP_W-1:0] OP_JALR = 4'b1001;

    function automatic logic op_is_jump(input logic [OP_W-1:0] op);
        return (op == OP_JAL) || (op == OP_JALR);
    endfunction

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE,
            OP_BLTU, OP_BGEU, OP_JAL, OP_JALR: legal = 1'b1;
            default:                           legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluator: decides taken/illegal for one op.
module branch_cond
    import branch_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken_c,
    output logic            illegal_c
);

    always_comb begin
        taken_c   = 1'b0;
        illegal_c = !op_is_legal(op);
        if (op_is_jump(op)) begin
            taken_c = 1'b1;
        end else begin
            case (op)
                OP_BEQ:  taken_c = (rs1 == rs2);
                OP_BNE:  taken_c = (rs1 != rs2);
                OP_BLT:  taken_c = ($signed(rs1) <  $signed(rs2));
                OP_BGE:  taken_c = ($signed(rs1) >= $signed(rs2));
                OP_BLTU: taken_c = (rs1 <  rs2);
                OP_BGEU: taken_c = (rs1 >= rs2);
                default: taken_c = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Two-stage branch resolution pipeline with valid/ready handshakes, flush and
// saturating retire statistics.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [PC_W-1:0]  in_pc,
    input  logic             in_pred_taken,
    input  logic [PC_W-1:0]  in_pred_target,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [PC_W-1:0]  out_target,
    output logic [PC_W-1:0]  out_link,
    output logic [PC_W-1:0]  out_redirect_pc,
    output logic             out_mispredict,
    output logic             out_misaligned,
    output logic             out_illegal,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispredicts
);

    logic            s1_valid;
    logic [OP_W-1:0] s1_op;
    logic [XLEN-1:0] s1_rs1;
    logic [XLEN-1:0] s1_rs2;
    logic [XLEN-1:0] s1_imm;
    logic [PC_W-1:0] s1_pc;
    logic            s1_pred_taken;
    logic [PC_W-1:0] s1_pred_target;

    logic            cond_taken_c;
    logic            cond_illegal_c;
    logic [XLEN-1:0] jalr_sum_c;
    logic [PC_W-1:0] jalr_pc_c;
    logic [PC_W-1:0] target_c;
    logic [PC_W-1:0] link_c;
    logic [PC_W-1:0] redirect_c;
    logic            mispredict_c;
    logic            misaligned_c;
    logic            s2_free_c;
    logic            retire_c;

    branch_cond #(.XLEN(XLEN)) u_cond (
        .op        (s1_op),
        .rs1       (s1_rs1),
        .rs2       (s1_rs2),
        .taken_c   (cond_taken_c),
        .illegal_c (cond_illegal_c)
    );

    // Resolve target, link and prediction check from the S1 request
    always_comb begin
        jalr_sum_c = s1_rs1 + s1_imm;
        jalr_pc_c  = PC_W'(jalr_sum_c);
        link_c     = s1_pc + PC_W'(LINK_OFFSET);
        target_c   = s1_pc + PC_W'(s1_imm);
        if (cond_illegal_c) begin
            target_c = link_c;
        end else if (s1_op == OP_JALR) begin
            target_c = jalr_pc_c & ~(PC_W'(1));
        end
        redirect_c   = cond_taken_c ? target_c : link_c;
        mispredict_c = !cond_illegal_c &
                       ((cond_taken_c != s1_pred_taken) |
                        (cond_taken_c & s1_pred_taken & (s1_pred_target != target_c)));
        misaligned_c = cond_taken_c & target_c[1];
    end

    assign in_ready  = !flush & (!s1_valid | !out_valid | out_ready);
    assign s2_free_c = !out_valid | out_ready;
    assign retire_c  = out_valid & out_ready & !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid         <= 1'b0;
            s1_op            <= '0;
            s1_rs1           <= '0;
            s1_rs2           <= '0;
            s1_imm           <= '0;
            s1_pc            <= '0;
            s1_pred_taken    <= 1'b0;
            s1_pred_target   <= '0;
            out_valid        <= 1'b0;
            out_taken        <= 1'b0;
            out_target       <= '0;
            out_link         <= '0;
            out_redirect_pc  <= '0;
            out_mispredict   <= 1'b0;
            out_misaligned   <= 1'b0;
            out_illegal      <= 1'b0;
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (flush) begin
                s1_valid  <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                // S1 refills whenever it is empty or draining into S2
                if (in_ready) begin
                    s1_valid <= in_valid;
                    if (in_valid) begin
                        s1_op          <= in_op;
                        s1_rs1         <= in_rs1;
                        s1_rs2         <= in_rs2;
                        s1_imm         <= in_imm;
                        s1_pc          <= in_pc;
                        s1_pred_taken  <= in_pred_taken;
                        s1_pred_target <= in_pred_target;
                    end
                end
                // S2 output registers only change once the held result is gone
                if (s2_free_c) begin
                    out_valid <= s1_valid;
                    if (s1_valid) begin
                        out_taken       <= cond_taken_c;
                        out_target      <= target_c;
                        out_link        <= link_c;
                        out_redirect_pc <= redirect_c;
                        out_mispredict  <= mispredict_c;
                        out_misaligned  <= misaligned_c;
                        out_illegal     <= cond_illegal_c;
                    end
                end
            end
            if (retire_c) begin
                if (stat_branches != '1) begin
                    stat_branches <= stat_branches + CNT_W'(1);
                end
                if (out_mispredict && (stat_mispredicts != '1)) begin
                    stat_mispredicts <= stat_mispredicts + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed cases plus random traffic
// checked against a behavioural model of the branch rules.
module tb_branch_resolve_unit;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CNT_MAX = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_rs1, in_rs2, in_imm, in_pc, in_pred_target;
    logic        in_pred_taken;
    logic        flush;
    logic        out_valid, out_ready;
    logic        out_taken, out_mispredict, out_misaligned, out_illegal;
    logic [31:0] out_target, out_link, out_redirect_pc;
    logic [CNT_W-1:0] stat_branches, stat_mispredicts;

    branch_resolve_unit #(.XLEN(32), .PC_W(32), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_op            (in_op),
        .in_rs1           (in_rs1),
        .in_rs2           (in_rs2),
        .in_imm           (in_imm),
        .in_pc            (in_pc),
        .in_pred_taken    (in_pred_taken),
        .in_pred_target   (in_pred_target),
        .flush            (flush),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_taken        (out_taken),
        .out_target       (out_target),
        .out_link         (out_link),
        .out_redirect_pc  (out_redirect_pc),
        .out_mispredict   (out_mispredict),
        .out_misaligned   (out_misaligned),
        .out_illegal      (out_illegal),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
        logic [31:0] link;
        logic [31:0] redirect;
        logic        mispredict;
        logic        misaligned;
        logic        illegal;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_accept = 0;
    int unsigned m_br = 0;
    int unsigned m_mp = 0;
    logic        prev_hold = 1'b0;
    logic [99:0] prev_out;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: branch semantics written straight from the ISA rules
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] rs1, rs2, imm, pc,
                                   input logic pt, input logic [31:0] ptgt);
        exp_t e;
        int signed   s1, s2;
        logic [31:0] sum;
        s1 = rs1;
        s2 = rs2;
        e = '0;
        e.link = pc + 32'd4;
        case (op)
            4'd0: e.taken = (rs1 == rs2);
            4'd1: e.taken = (rs1 != rs2);
            4'd4: e.taken = (s1 < s2);
            4'd5: e.taken = (s1 >= s2);
            4'd6: e.taken = (rs1 < rs2);
            4'd7: e.taken = (rs1 >= rs2);
            4'd8, 4'd9: e.taken = 1'b1;
            default: e.illegal = 1'b1;
        endcase
        if (e.illegal) e.target = e.link;
        else if (op == 4'd9) begin
            sum = rs1 + imm;
            e.target = {sum[31:1], 1'b0};
        end else e.target = pc + imm;
        e.redirect   = e.taken ? e.target : e.link;
        e.mispredict = !e.illegal && ((e.taken != pt) || (e.taken && pt && ptgt != e.target));
        e.misaligned = e.taken && e.target[1];
        return e;
    endfunction

    function automatic int unsigned sat_inc(input int unsigned v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    // Monitor: pushes on accept, pops/compares on retire, tracks counters
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            m_br = 0;
            m_mp = 0;
            prev_hold = 1'b0;
        end else begin
            check("stat_branches", 128'(stat_branches), 128'(m_br));
            check("stat_mispredicts", 128'(stat_mispredicts), 128'(m_mp));
            if (prev_hold)
                check("hold_stable", 128'({out_taken, out_target, out_link, out_redirect_pc,
                                           out_mispredict, out_misaligned, out_illegal}),
                      128'(prev_out));
            if (out_valid && sb_q.size() == 0)
                check("spurious_out_valid", 128'(out_valid), 128'(0));
            if (flush) begin
                sb_q.delete();
            end else begin
                if (out_valid && out_ready && sb_q.size() > 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("out_taken", 128'(out_taken), 128'(e.taken));
                    check("out_target", 128'(out_target), 128'(e.target));
                    check("out_link", 128'(out_link), 128'(e.link));
                    check("out_redirect_pc", 128'(out_redirect_pc), 128'(e.redirect));
                    check("out_mispredict", 128'(out_mispredict), 128'(e.mispredict));
                    check("out_misaligned", 128'(out_misaligned), 128'(e.misaligned));
                    check("out_illegal", 128'(out_illegal), 128'(e.illegal));
                    m_br = sat_inc(m_br);
                    if (e.mispredict) m_mp = sat_inc(m_mp);
                end
                if (in_valid && in_ready) begin
                    sb_q.push_back(model(in_op, in_rs1, in_rs2, in_imm, in_pc,
                                         in_pred_taken, in_pred_target));
                    n_accept++;
                end
            end
            prev_hold = out_valid && !out_ready && !flush;
            prev_out  = {out_taken, out_target, out_link, out_redirect_pc,
                         out_mispredict, out_misaligned, out_illegal};
        end
    end

    task automatic set_req(input logic [3:0] op, input logic [31:0] rs1, rs2, imm, pc,
                           input logic pt, input logic [31:0] ptgt);
        in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_pc = pc;
        in_pred_taken = pt; in_pred_target = ptgt;
    endtask

    // Present one request until accepted; caller is just after a rising edge
    task automatic issue(input logic [3:0] op, input logic [31:0] rs1, rs2, imm, pc,
                         input logic pt, input logic [31:0] ptgt);
        logic acc;
        acc = 1'b0;
        set_req(op, rs1, rs2, imm, pc, pt, ptgt);
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
        end
        if (!acc) check("issue_timeout", 128'(acc), 128'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            done = (sb_q.size() == 0) && !out_valid;
        end
        if (!done) check("drain_timeout", 128'(done), 128'(1));
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [3:0]  ops [11];
        logic [3:0]  op;
        logic [31:0] a, b, imm, pc;
        int          acc0;
        logic [CNT_W-1:0] sb_before, sm_before;

        ops = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd2, 4'd3, 4'd15};
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        set_req(4'd0, 0, 0, 0, 0, 1'b0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_out_valid", 128'(out_valid), 128'(0));
        check("reset_in_ready", 128'(in_ready), 128'(1));
        check("reset_out_target", 128'(out_target), 128'(0));
        @(posedge clk); #1;

        // BEQ taken, correctly predicted; request driven after edge N shows after N+2
        set_req(4'd0, 32'd5, 32'd5, 32'h20, 32'h100, 1'b1, 32'h120);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("latency_early", 128'(out_valid), 128'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check("latency_valid", 128'(out_valid), 128'(1));
        check("beq_taken", 128'(out_taken), 128'(1));
        check("beq_target", 128'(out_target), 128'(32'h120));
        check("beq_mispredict", 128'(out_mispredict), 128'(0));
        @(posedge clk); #1;
        drain();

        // Signed vs unsigned compare on the same operands
        issue(4'd4, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h200, 1'b1, 32'h240);
        issue(4'd6, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h300, 1'b1, 32'h340);
        @(negedge clk);
        check("blt_taken", 128'(out_taken), 128'(1));
        @(posedge clk); #1;
        @(negedge clk);
        check("bltu_taken", 128'(out_taken), 128'(0));
        check("bltu_redirect", 128'(out_redirect_pc), 128'(32'h304));
        check("bltu_mispredict", 128'(out_mispredict), 128'(1));
        @(posedge clk); #1;
        drain();

        // JALR to an odd address: bit 0 cleared, bit 1 flags misalignment
        issue(4'd9, 32'h1003, 32'd0, 32'd0, 32'h400, 1'b0, 32'h0);
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("jalr_target", 128'(out_target), 128'(32'h1002));
        check("jalr_misaligned", 128'(out_misaligned), 128'(1));
        check("jalr_link", 128'(out_link), 128'(32'h404));
        @(posedge clk); #1;
        drain();

        // Backpressure: only two of three requests fit while the consumer stalls
        out_ready = 1'b0;
        acc0 = n_accept;
        for (int c = 0; c < 5; c++) begin
            set_req(4'd1, 32'(c), 32'd7, 32'h10, 32'h500 + 32'(n_accept - acc0) * 4, 1'b0, 0);
            in_valid = (n_accept - acc0) < 3;
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("stall_accepted", 128'(n_accept - acc0), 128'(2));
        check("stall_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        set_req(4'd1, 32'd2, 32'd7, 32'h10, 32'h508, 1'b0, 0);
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("b2b_out_valid", 128'(out_valid), 128'(1));
            if (i == 0) check("accept_with_retire", 128'(in_ready), 128'(1));
            @(posedge clk); #1;
            if (i == 0) in_valid = 1'b0;
        end
        drain();

        // Flush with two entries in flight and a new request offered
        out_ready = 1'b0;
        issue(4'd8, 0, 0, 32'h80, 32'h600, 1'b0, 0);
        issue(4'd8, 0, 0, 32'h80, 32'h604, 1'b0, 0);
        set_req(4'd0, 1, 1, 32'h8, 32'h608, 1'b0, 0);
        in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 128'(in_ready), 128'(0));
        sb_before = stat_branches;
        sm_before = stat_mispredicts;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 128'(out_valid), 128'(0));
        check("flush_stat_br", 128'(stat_branches), 128'(sb_before));
        check("flush_stat_mp", 128'(stat_mispredicts), 128'(sm_before));
        @(posedge clk); #1;
        drain();

        // Random traffic with random backpressure and occasional flush
        for (int c = 0; c < 600; c++) begin
            op  = ops[$urandom_range(0, 10)];
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 8)) : $urandom);
            imm = 32'($signed(13'($urandom_range(0, 8191)))) & ~32'd1;
            pc  = $urandom & ~32'd3;
            set_req(op, a, b, imm, pc, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 1) == 0) ? pc + imm : $urandom);
            in_valid  = $urandom_range(0, 2) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            flush     = $urandom_range(0, 39) == 0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; flush = 1'b0;
        drain();

        // Counter saturation from a clean start
        do_reset();
        for (int i = 0; i < 20; i++)
            issue(4'd0, 32'd1, 32'd2, 32'h40, 32'h700 + 32'(i) * 4, 1'b1, 32'h740);
        drain();
        @(negedge clk);
        check("sat_branches", 128'(stat_branches), 128'(15));
        check("sat_mispredicts", 128'(stat_mispredicts), 128'(15));
        @(posedge clk); #1;

        // Reset with an entry held under backpressure
        out_ready = 1'b0;
        issue(4'd8, 0, 0, 32'h10, 32'h800, 1'b0, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_stat_br", 128'(stat_branches), 128'(0));
        check("rst_stat_mp", 128'(stat_mispredicts), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_no_ghost", 128'(out_valid), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
